ola_trigger_sequencer: RTL and testbench

Multi-stage trigger controller for the logic analyzer capture path. It sits between the sample source and the capture memory controller and holds per-stage mask/value/count configuration. It walks a sequence of up to `stages` match conditions over the valid sample stream and asserts a one-cycle `trigger` when the final stage completes. Samples pass through a one-stage register so that `trigger` is aligned with the sample that completed the sequence.

---
 rtl/ola_trigger_sequencer_pkg.sv | 26 ++
 rtl/ola_trigger_sequencer_if.sv | 40 ++++
 rtl/ola_trigger_sequencer_match.sv | 24 ++
 rtl/ola_trigger_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_ola_trigger_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ola_trigger_sequencer_pkg.sv
// ola_pkg: shared types and constants for the logic analyzer trigger sequencer.
//
// Contents:
//   state_e            sequencer state (IDLE / ARMED / FIRED)
//   CFG_MASK..GLOBAL   cfg_sel encodings for the configuration write port
//   GLB_LAST_IDX       cfg_stage index of the last-stage register inside the global bank
//   GLB_TIMEOUT_IDX    cfg_stage index of the timeout register inside the global bank
//
// Optional feature macro used by the sequencer: OLA_TRIGGER_SEQ_TIMEOUT_EN
package ola_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_e;

    localparam logic [1:0] CFG_MASK   = 2'd0;
    localparam logic [1:0] CFG_VALUE  = 2'd1;
    localparam logic [1:0] CFG_COUNT  = 2'd2;
    localparam logic [1:0] CFG_GLOBAL = 2'd3;

    localparam int GLB_LAST_IDX    = 0;
    localparam int GLB_TIMEOUT_IDX = 1;

endpackage

// File: rtl/ola_trigger_sequencer_if.sv
// ola_trigger_sequencer_if: configuration write bus plus the sample stream
// passing through the trigger sequencer.
//
// Signals:
//   cfg_we / cfg_stage / cfg_sel / cfg_data   configuration write port
//   in_valid / in_sample                      incoming sample stream
//   out_valid / out_sample                    sample stream delayed one cycle
//
// Modports:
//   master  drives configuration and incoming samples, receives delayed samples
//   slave   the sequencer side
interface ola_trigger_sequencer_if
    import ola_pkg::*;
#(
    parameter int width  = 8,
    parameter int stages = 4,
    parameter int cwidth = 16
);
    localparam int sw = $clog2(stages);

    logic              cfg_we;
    logic [sw-1:0]     cfg_stage;
    logic [1:0]        cfg_sel;
    logic [cwidth-1:0] cfg_data;
    logic              in_valid;
    logic [width-1:0]  in_sample;
    logic              out_valid;
    logic [width-1:0]  out_sample;

    modport master (
        output cfg_we, cfg_stage, cfg_sel, cfg_data, in_valid, in_sample,
        input  out_valid, out_sample
    );

    modport slave (
        input  cfg_we, cfg_stage, cfg_sel, cfg_data, in_valid, in_sample,
        output out_valid, out_sample
    );

endinterface

// File: rtl/ola_trigger_sequencer_match.sv
// ola_trigger_match: combinational mask/value comparator for one trigger stage.
//
// Ports:
//   valid   in  sample strobe; no match is reported without it
//   sample  in  sample under test
//   mask    in  bits that take part in the compare (0 = don't care)
//   value   in  required value on the masked bits
//   match   out valid sample equal to value on every masked bit
module ola_trigger_match
    import ola_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             valid,
    input  logic [width-1:0] sample,
    input  logic [width-1:0] mask,
    input  logic [width-1:0] value,
    output logic             match
);

    // A zero mask reduces both sides to zero, so every valid sample matches.
    assign match = valid && ((sample & mask) == (value & mask));

endmodule

// File: rtl/ola_trigger_sequencer.sv
// ola_trigger_sequencer: multi-stage trigger controller for the capture path.
// Walks up to `stages` mask/value/count conditions over the valid sample
// stream and pulses `trigger` together with the delayed copy of the sample
// that completed the final stage.
//
// Ports:
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset, clears state and all config
//   bus       slave modport of ola_trigger_sequencer_if (config port, samples in/out)
//   arm       in   start the sequence at stage 0
//   disarm    in   abort and return to IDLE (wins over arm)
//   trigger   out  one-cycle pulse aligned with out_valid of the completing sample
//   armed     out  sequencer is in ARMED
//   fired     out  sequencer is in FIRED
//   stage     out  current stage index
//
// Optional feature: define OLA_TRIGGER_SEQ_TIMEOUT_EN to add a per-stage
// timeout that falls back to stage 0 when a later stage takes too long.
module ola_trigger_sequencer
    import ola_pkg::*;
#(
    parameter int width  = 8,
    parameter int stages = 4,
    parameter int cwidth = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    ola_trigger_sequencer_if.slave    bus,
    input  logic                      arm,
    input  logic                      disarm,
    output logic                      trigger,
    output logic                      armed,
    output logic                      fired,
    output logic [$clog2(stages)-1:0] stage
);

    localparam int sw = $clog2(stages);

    state_e            state_q, state_d;
    logic [sw-1:0]     stage_q, stage_d;
    logic [sw-1:0]     last_q, last_d;
    logic [cwidth-1:0] run_q, run_d;
    logic              trigger_q, trigger_d;
    logic              out_valid_q, out_valid_d;
    logic [width-1:0]  out_sample_q, out_sample_d;

    logic [width-1:0]  mask_q  [stages];
    logic [width-1:0]  mask_d  [stages];
    logic [width-1:0]  value_q [stages];
    logic [width-1:0]  value_d [stages];
    logic [cwidth-1:0] count_q [stages];
    logic [cwidth-1:0] count_d [stages];

`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
    logic [cwidth-1:0] timeout_q, timeout_d;
    logic [cwidth-1:0] tcnt_q, tcnt_d;
    logic [cwidth-1:0] tcnt_inc;
`endif

    logic [width-1:0]  sel_mask;
    logic [width-1:0]  sel_value;
    logic [cwidth-1:0] sel_count;
    logic [cwidth-1:0] run_target;
    logic [cwidth-1:0] run_inc;
    logic              match;
    logic              stage_done;

    // Only the current stage's configuration is ever compared, so a single
    // comparator fed from muxed registers covers the whole sequence.
    assign sel_mask  = mask_q[stage_q];
    assign sel_value = value_q[stage_q];
    assign sel_count = count_q[stage_q];

    ola_trigger_match #(
        .width (width)
    ) u_match (
        .valid  (bus.in_valid),
        .sample (bus.in_sample),
        .mask   (sel_mask),
        .value  (sel_value),
        .match  (match)
    );

    // A count of 0 behaves like 1 so a stage can never complete on zero samples.
    assign run_target = (sel_count == '0) ? cwidth'(1) : sel_count;
    assign run_inc    = run_q + cwidth'(1);
    assign stage_done = (state_q == ARMED) && match && (run_inc == run_target);

`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
    assign tcnt_inc = tcnt_q + cwidth'(1);
`endif

    // Next-state logic: config writes (IDLE only), then disarm/arm priority,
    // then sample evaluation while ARMED. A sample arriving with arm is skipped.
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        last_d       = last_q;
        run_d        = run_q;
        trigger_d    = 1'b0;
        out_valid_d  = bus.in_valid;
        out_sample_d = bus.in_sample;
        mask_d       = mask_q;
        value_d      = value_q;
        count_d      = count_q;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
        timeout_d    = timeout_q;
        tcnt_d       = tcnt_q;
`endif

        if ((state_q == IDLE) && bus.cfg_we) begin
            case (bus.cfg_sel)
                CFG_MASK:  mask_d[bus.cfg_stage]  = bus.cfg_data[width-1:0];
                CFG_VALUE: value_d[bus.cfg_stage] = bus.cfg_data[width-1:0];
                CFG_COUNT: count_d[bus.cfg_stage] = bus.cfg_data;
                CFG_GLOBAL: begin
                    if (bus.cfg_stage == sw'(GLB_LAST_IDX)) begin
                        last_d = bus.cfg_data[sw-1:0];
                    end
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
                    else if (bus.cfg_stage == sw'(GLB_TIMEOUT_IDX)) begin
                        timeout_d = bus.cfg_data;
                    end
`endif
                end
                default: ;
            endcase
        end

        if (disarm) begin
            state_d = IDLE;
            stage_d = '0;
            run_d   = '0;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
            tcnt_d  = '0;
`endif
        end else if (arm) begin
            state_d = ARMED;
            stage_d = '0;
            run_d   = '0;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
            tcnt_d  = '0;
`endif
        end else if ((state_q == ARMED) && bus.in_valid) begin
            if (stage_done) begin
                run_d = '0;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
                tcnt_d = '0;
`endif
                if (stage_q == last_q) begin
                    state_d   = FIRED;
                    trigger_d = 1'b1;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end else if (match) begin
                run_d = run_inc;
            end else begin
                run_d = '0;
            end
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
            // Timeout counts every valid sample since the last advance; a
            // completion in the same cycle already cleared it above.
            if (!stage_done && (stage_q != '0) && (timeout_q != '0)) begin
                if (tcnt_inc >= timeout_q) begin
                    stage_d = '0;
                    run_d   = '0;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
`endif
        end
    end

    // State, config and the one-cycle sample delay; reset clears everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            stage_q      <= '0;
            last_q       <= '0;
            run_q        <= '0;
            trigger_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            for (int i = 0; i < stages; i++) begin
                mask_q[i]  <= '0;
                value_q[i] <= '0;
                count_q[i] <= '0;
            end
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
            timeout_q    <= '0;
            tcnt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            last_q       <= last_d;
            run_q        <= run_d;
            trigger_q    <= trigger_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            mask_q       <= mask_d;
            value_q      <= value_d;
            count_q      <= count_d;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
            timeout_q    <= timeout_d;
            tcnt_q       <= tcnt_d;
`endif
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_sample_q;
    assign trigger        = trigger_q;
    assign armed          = (state_q == ARMED);
    assign fired          = (state_q == FIRED);
    assign stage          = stage_q;

endmodule

// File: tb/tb_ola_trigger_sequencer.sv
// tb_ola_trigger_sequencer: directed self-checking bench for ola_trigger_sequencer.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge that consumed them.
module tb_ola_trigger_sequencer;
    import ola_pkg::*;

    localparam int width  = 8;
    localparam int stages = 4;
    localparam int cwidth = 16;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       arm     = 1'b0;
    logic       disarm  = 1'b0;
    logic       trigger;
    logic       armed;
    logic       fired;
    logic [1:0] stage;

    int compare_count = 0;
    int fail_count    = 0;
    logic [1:0] timeout_stage_exp;

    ola_trigger_sequencer_if #(
        .width  (width),
        .stages (stages),
        .cwidth (cwidth)
    ) bus ();

    ola_trigger_sequencer #(
        .width  (width),
        .stages (stages),
        .cwidth (cwidth)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .arm     (arm),
        .disarm  (disarm),
        .trigger (trigger),
        .armed   (armed),
        .fired   (fired),
        .stage   (stage)
    );

    always #5 clock = ~clock;

    // One compare with an immediate assertion; failures are counted and reported.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Checks the status outputs as a group.
    task automatic checkStatus(input string tag, input logic t, input logic a,
                               input logic f, input logic [1:0] s);
        checkOutput({tag, ".trigger"}, {31'd0, trigger}, {31'd0, t});
        checkOutput({tag, ".armed"},   {31'd0, armed},   {31'd0, a});
        checkOutput({tag, ".fired"},   {31'd0, fired},   {31'd0, f});
        checkOutput({tag, ".stage"},   {30'd0, stage},   {30'd0, s});
    endtask

    // Drives one cycle of sample/arm/disarm, returns just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] s,
                                 input logic a, input logic d);
        @(negedge clock);
        bus.cfg_we    = 1'b0;
        bus.in_valid  = v;
        bus.in_sample = s;
        arm           = a;
        disarm        = d;
        @(posedge clock);
        #1;
    endtask

    // One configuration write cycle with no sample and no arm/disarm.
    task automatic cfgWrite(input logic [1:0] stg, input logic [1:0] sel,
                            input logic [15:0] data);
        @(negedge clock);
        bus.cfg_we    = 1'b1;
        bus.cfg_stage = stg;
        bus.cfg_sel   = sel;
        bus.cfg_data  = data;
        bus.in_valid  = 1'b0;
        bus.in_sample = 8'h00;
        arm           = 1'b0;
        disarm        = 1'b0;
        @(posedge clock);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_stage = 2'd0;
        bus.cfg_sel   = 2'd0;
        bus.cfg_data  = 16'h0000;
        bus.in_valid  = 1'b0;
        bus.in_sample = 8'h00;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        checkStatus("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        checkOutput("reset.out_valid",  {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset.out_sample", {24'd0, bus.out_sample}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single stage: 0x5A, count 1, last 0
        cfgWrite(2'd0, CFG_MASK,   16'h00FF);
        cfgWrite(2'd0, CFG_VALUE,  16'h005A);
        cfgWrite(2'd0, CFG_COUNT,  16'd1);
        cfgWrite(2'd0, CFG_GLOBAL, 16'd0);
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
        checkStatus("s1.arm", 1'b0, 1'b1, 1'b0, 2'd0);
        checkOutput("s1.arm.out_sample", {24'd0, bus.out_sample}, 32'h33);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        checkStatus("s1.miss", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkStatus("s1.hit", 1'b1, 1'b0, 1'b1, 2'd0);
        checkOutput("s1.hit.out_sample", {24'd0, bus.out_sample}, 32'h5A);
        checkOutput("s1.hit.out_valid",  {31'd0, bus.out_valid}, 32'd1);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkStatus("s1.fired_hold", 1'b0, 1'b0, 1'b1, 2'd0);

        // Two stages with a broken run in stage 0
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkStatus("s2.disarm", 1'b0, 1'b0, 1'b0, 2'd0);
        cfgWrite(2'd0, CFG_VALUE,  16'h0001);
        cfgWrite(2'd0, CFG_COUNT,  16'd3);
        cfgWrite(2'd1, CFG_MASK,   16'h00FF);
        cfgWrite(2'd1, CFG_VALUE,  16'h0002);
        cfgWrite(2'd1, CFG_COUNT,  16'd0);
        cfgWrite(2'd0, CFG_GLOBAL, 16'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        checkStatus("s2.break", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        checkStatus("s2.run2", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        checkStatus("s2.adv", 1'b0, 1'b1, 1'b0, 2'd1);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
        checkStatus("s2.hit", 1'b1, 1'b0, 1'b1, 2'd1);
        checkOutput("s2.hit.out_sample", {24'd0, bus.out_sample}, 32'h02);

        // Invalid gaps between matches leave the run untouched
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        cfgWrite(2'd0, CFG_VALUE,  16'h005A);
        cfgWrite(2'd0, CFG_COUNT,  16'd2);
        cfgWrite(2'd0, CFG_GLOBAL, 16'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkStatus("s3.first", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("s3.gap.out_valid", {31'd0, bus.out_valid}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkStatus("s3.gap", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkStatus("s3.hit", 1'b1, 1'b0, 1'b1, 2'd0);
        checkOutput("s3.hit.out_sample", {24'd0, bus.out_sample}, 32'h5A);

        // Config write while ARMED is ignored; arm+disarm together -> IDLE
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        cfgWrite(2'd0, CFG_COUNT, 16'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        cfgWrite(2'd0, CFG_VALUE, 16'h0077);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        checkStatus("s4.ignored", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);
        checkStatus("s4.both", 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkStatus("s4.oldval", 1'b1, 1'b0, 1'b1, 2'd0);

        // Mask of zero matches any valid sample
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        cfgWrite(2'd0, CFG_MASK, 16'h0000);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        checkStatus("s5.mask0", 1'b1, 1'b0, 1'b1, 2'd0);

        // Timeout of 2 after stage 0 completes (only active with the macro)
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        cfgWrite(2'd0, CFG_MASK,   16'h00FF);
        cfgWrite(2'd0, CFG_VALUE,  16'h0001);
        cfgWrite(2'd1, CFG_COUNT,  16'd1);
        cfgWrite(2'd0, CFG_GLOBAL, 16'd1);
        cfgWrite(2'd1, CFG_GLOBAL, 16'd2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        checkStatus("s6.adv", 1'b0, 1'b1, 1'b0, 2'd1);
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
        checkStatus("s6.wait1", 1'b0, 1'b1, 1'b0, 2'd1);
        applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
        timeout_stage_exp = 2'd0;
`else
        timeout_stage_exp = 2'd1;
`endif
        checkStatus("s6.wait2", 1'b0, 1'b1, 1'b0, timeout_stage_exp);

        // arm while ARMED restarts at stage 0
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkStatus("s7.rearm", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        checkStatus("s7.adv", 1'b0, 1'b1, 1'b0, 2'd1);

        // Asynchronous reset mid-sequence clears outputs and config
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkStatus("s8.reset", 1'b0, 1'b0, 1'b0, 2'd0);
        checkOutput("s8.reset.out_valid",  {31'd0, bus.out_valid}, 32'd0);
        checkOutput("s8.reset.out_sample", {24'd0, bus.out_sample}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        checkStatus("s8.noarm", 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hAB, 1'b0, 1'b0);
        checkStatus("s8.cleared_cfg", 1'b1, 1'b0, 1'b1, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
